// File: rtl/decode_control_pipe.sv
// decode_control_pipe: registered main decoder for the decode stage.
// Turns RV32I / Zicsr / A opcodes into a datapath control word one cycle
// after acceptance. AMO read-modify-write instructions are split into a
// read phase and a write phase. Unknown opcodes are not flagged during a
// short window that follows reset or flush.
module decode_control_pipe #(
    parameter int INVALID_WINDOW = 2,
    parameter bit EN_CSR         = 1'b1,
    parameter bit EN_ATOMIC      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       stall,
    input  logic       in_valid,
    input  logic [6:0] opcode,
    input  logic [4:0] funct5,
    output logic       out_valid,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_read,
    output logic       branch,
    output logic       alu_src,
    output logic       jump,
    output logic       lui,
    output logic       auipc,
    output logic       jal,
    output logic       r_type,
    output logic       csr_type,
    output logic       is_atomic,
    output logic [1:0] mem_csr_to_reg,
    output logic [1:0] alu_op,
    output logic       amo_phase,
    output logic       busy,
    output logic       invalid_inst
);

    // The counter must hold INVALID_WINDOW; a zero window still needs one bit.
    localparam int WIN_W = (INVALID_WINDOW < 1) ? 1 : $clog2(INVALID_WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(INVALID_WINDOW);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;
    localparam logic [6:0] OP_AMO   = 7'b0101111;

    localparam logic [4:0] F5_LR = 5'b00010;
    localparam logic [4:0] F5_SC = 5'b00011;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_CSR = 2'b10;

    localparam logic [1:0] ALU_ADDR = 2'b00;
    localparam logic [1:0] ALU_I    = 2'b01;
    localparam logic [1:0] ALU_B    = 2'b10;
    localparam logic [1:0] ALU_R    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       alu_src;
        logic       jump;
        logic       lui;
        logic       auipc;
        logic       jal;
        logic       r_type;
        logic       csr_type;
        logic       is_atomic;
        logic [1:0] mem_csr_to_reg;
        logic [1:0] alu_op;
        logic       amo_phase;
    } ctrl_t;

    typedef enum logic {
        DECODE = 1'b0,
        AMO_WR = 1'b1
    } state_t;

    function automatic ctrl_t nop_word();
        ctrl_t w;
        w                = '0;
        w.mem_csr_to_reg = WB_ALU;
        w.alu_op         = ALU_R;
        return w;
    endfunction

    function automatic ctrl_t amo_wr_word();
        ctrl_t w;
        w           = nop_word();
        w.is_atomic = 1'b1;
        w.r_type    = 1'b1;
        w.mem_write = 1'b1;
        w.amo_phase = 1'b1;
        return w;
    endfunction

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             out_valid_q, out_valid_d;
    logic             invalid_q, invalid_d;
    logic [WIN_W-1:0] win_cnt;

    ctrl_t dec_word;
    logic  dec_unknown;
    logic  dec_amo;

    // Opcode/funct5 to control word; flags unknown opcodes and AMO starts.
    always_comb begin
        dec_word    = nop_word();
        dec_unknown = 1'b0;
        dec_amo     = 1'b0;
        case (opcode)
            OP_R: begin
                dec_word.reg_write = 1'b1;
                dec_word.r_type    = 1'b1;
                dec_word.alu_op    = ALU_R;
            end
            OP_I: begin
                dec_word.reg_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.alu_op    = ALU_I;
            end
            OP_LOAD: begin
                dec_word.reg_write      = 1'b1;
                dec_word.mem_read       = 1'b1;
                dec_word.alu_src        = 1'b1;
                dec_word.mem_csr_to_reg = WB_MEM;
                dec_word.alu_op         = ALU_ADDR;
            end
            OP_STORE: begin
                dec_word.mem_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.alu_op    = ALU_ADDR;
            end
            OP_B: begin
                dec_word.branch = 1'b1;
                dec_word.alu_op = ALU_B;
            end
            OP_JAL: begin
                dec_word.reg_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.jump      = 1'b1;
                dec_word.jal       = 1'b1;
                dec_word.alu_op    = ALU_ADDR;
            end
            OP_JALR: begin
                dec_word.reg_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.jump      = 1'b1;
                dec_word.alu_op    = ALU_ADDR;
            end
            OP_LUI: begin
                dec_word.reg_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.lui       = 1'b1;
                dec_word.alu_op    = ALU_ADDR;
            end
            OP_AUIPC: begin
                dec_word.reg_write = 1'b1;
                dec_word.alu_src   = 1'b1;
                dec_word.auipc     = 1'b1;
                dec_word.alu_op    = ALU_ADDR;
            end
            OP_CSR: begin
                if (EN_CSR) begin
                    dec_word.reg_write      = 1'b1;
                    dec_word.csr_type       = 1'b1;
                    dec_word.mem_csr_to_reg = WB_CSR;
                    dec_word.alu_op         = ALU_R;
                end else begin
                    dec_unknown = 1'b1;
                end
            end
            OP_AMO: begin
                if (EN_ATOMIC) begin
                    dec_word.is_atomic      = 1'b1;
                    dec_word.r_type         = 1'b1;
                    dec_word.alu_op         = ALU_R;
                    dec_word.reg_write      = 1'b1;
                    dec_word.mem_csr_to_reg = WB_MEM;
                    if (funct5 == F5_SC) begin
                        dec_word.mem_write = 1'b1;
                    end else begin
                        // LR and the AMO read phase both read memory; only
                        // true AMOs need the follow-up write phase.
                        dec_word.mem_read = 1'b1;
                        dec_amo           = (funct5 != F5_LR);
                    end
                end else begin
                    dec_unknown = 1'b1;
                end
            end
            default: dec_unknown = 1'b1;
        endcase
    end

    // Next state and next registered outputs; stall keeps everything as is.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        out_valid_d = out_valid_q;
        invalid_d   = invalid_q;
        if (!stall) begin
            case (state_q)
                DECODE: begin
                    if (in_valid) begin
                        ctrl_d      = dec_word;
                        out_valid_d = 1'b1;
                        invalid_d   = dec_unknown && (win_cnt == '0);
                        if (dec_amo) state_d = AMO_WR;
                    end else begin
                        ctrl_d      = nop_word();
                        out_valid_d = 1'b0;
                        invalid_d   = 1'b0;
                    end
                end
                AMO_WR: begin
                    // Upstream is held by busy, so in_valid is not looked at.
                    ctrl_d      = amo_wr_word();
                    out_valid_d = 1'b1;
                    invalid_d   = 1'b0;
                    state_d     = DECODE;
                end
                default: state_d = DECODE;
            endcase
        end
    end

    // State and output registers; flush drops any pending AMO write phase.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q     <= DECODE;
            ctrl_q      <= nop_word();
            out_valid_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            out_valid_q <= out_valid_d;
            invalid_q   <= invalid_d;
        end
    end

    // Invalid-opcode suppression window; keeps counting through stalls.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            win_cnt <= WIN_LOAD;
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end

    assign out_valid      = out_valid_q;
    assign invalid_inst   = invalid_q;
    assign busy           = (state_q == AMO_WR);
    assign reg_write      = ctrl_q.reg_write;
    assign mem_write      = ctrl_q.mem_write;
    assign mem_read       = ctrl_q.mem_read;
    assign branch         = ctrl_q.branch;
    assign alu_src        = ctrl_q.alu_src;
    assign jump           = ctrl_q.jump;
    assign lui            = ctrl_q.lui;
    assign auipc          = ctrl_q.auipc;
    assign jal            = ctrl_q.jal;
    assign r_type         = ctrl_q.r_type;
    assign csr_type       = ctrl_q.csr_type;
    assign is_atomic      = ctrl_q.is_atomic;
    assign mem_csr_to_reg = ctrl_q.mem_csr_to_reg;
    assign alu_op         = ctrl_q.alu_op;
    assign amo_phase      = ctrl_q.amo_phase;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Bench for decode_control_pipe: a full-featured instance and one with
// CSR/atomics disabled run on the same inputs against a cycle model.
module tb_decode_control_pipe;

    logic       clk = 1'b0;
    logic       reset, flush, stall, in_valid;
    logic [6:0] opcode;
    logic [4:0] funct5;

    // Outputs of both instances, index 0 = full, 1 = no CSR/atomic.
    logic [1:0] ov, rw, mw, mr, br, as, jp, lu, au, jl, rt, ct, ia, ph, bz, inv;
    logic [1:0] m2r [2];
    logic [1:0] aop [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_control_pipe u_dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .opcode(opcode), .funct5(funct5),
        .out_valid(ov[0]), .reg_write(rw[0]), .mem_write(mw[0]), .mem_read(mr[0]),
        .branch(br[0]), .alu_src(as[0]), .jump(jp[0]), .lui(lu[0]), .auipc(au[0]),
        .jal(jl[0]), .r_type(rt[0]), .csr_type(ct[0]), .is_atomic(ia[0]),
        .mem_csr_to_reg(m2r[0]), .alu_op(aop[0]), .amo_phase(ph[0]),
        .busy(bz[0]), .invalid_inst(inv[0])
    );

    decode_control_pipe #(.INVALID_WINDOW(2), .EN_CSR(1'b0), .EN_ATOMIC(1'b0)) u_dut_na (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .in_valid(in_valid), .opcode(opcode), .funct5(funct5),
        .out_valid(ov[1]), .reg_write(rw[1]), .mem_write(mw[1]), .mem_read(mr[1]),
        .branch(br[1]), .alu_src(as[1]), .jump(jp[1]), .lui(lu[1]), .auipc(au[1]),
        .jal(jl[1]), .r_type(rt[1]), .csr_type(ct[1]), .is_atomic(ia[1]),
        .mem_csr_to_reg(m2r[1]), .alu_op(aop[1]), .amo_phase(ph[1]),
        .busy(bz[1]), .invalid_inst(inv[1])
    );

    // Reference model state per instance.
    bit          m_amo_pending [2];
    int          m_window      [2];
    logic [16:0] m_word        [2];
    bit          m_ov          [2];
    bit          m_inv         [2];
    localparam int WINDOW = 2;

    function automatic logic [16:0] pack(input bit rw_, mw_, mr_, br_, as_, jp_, lu_, au_,
                                         jl_, rt_, ct_, ia_, input bit [1:0] wb, op,
                                         input bit phase);
        return {rw_, mw_, mr_, br_, as_, jp_, lu_, au_, jl_, rt_, ct_, ia_, wb, op, phase};
    endfunction

    function automatic logic [16:0] nop();
        return pack(0,0,0,0,0,0,0,0,0,0,0,0, 2'd0, 2'd3, 0);
    endfunction

    // Decode table straight from the instruction-class description.
    function automatic logic [16:0] ref_decode(input logic [6:0] op, input logic [4:0] f5,
                                               input bit en_csr, input bit en_at,
                                               output bit unknown, output bit starts_amo);
        unknown    = 0;
        starts_amo = 0;
        if (op == 7'b0110011) return pack(1,0,0,0,0,0,0,0,0,1,0,0, 2'd0, 2'd3, 0);
        if (op == 7'b0010011) return pack(1,0,0,0,1,0,0,0,0,0,0,0, 2'd0, 2'd1, 0);
        if (op == 7'b0000011) return pack(1,0,1,0,1,0,0,0,0,0,0,0, 2'd1, 2'd0, 0);
        if (op == 7'b0100011) return pack(0,1,0,0,1,0,0,0,0,0,0,0, 2'd0, 2'd0, 0);
        if (op == 7'b1100011) return pack(0,0,0,1,0,0,0,0,0,0,0,0, 2'd0, 2'd2, 0);
        if (op == 7'b1101111) return pack(1,0,0,0,1,1,0,0,1,0,0,0, 2'd0, 2'd0, 0);
        if (op == 7'b1100111) return pack(1,0,0,0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, 0);
        if (op == 7'b0110111) return pack(1,0,0,0,1,0,1,0,0,0,0,0, 2'd0, 2'd0, 0);
        if (op == 7'b0010111) return pack(1,0,0,0,1,0,0,1,0,0,0,0, 2'd0, 2'd0, 0);
        if (op == 7'b1110011 && en_csr) return pack(1,0,0,0,0,0,0,0,0,0,1,0, 2'd2, 2'd3, 0);
        if (op == 7'b0101111 && en_at) begin
            if (f5 == 5'b00011) return pack(1,1,0,0,0,0,0,0,0,1,0,1, 2'd1, 2'd3, 0);
            starts_amo = (f5 != 5'b00010);
            return pack(1,0,1,0,0,0,0,0,0,1,0,1, 2'd1, 2'd3, 0);
        end
        unknown = 1;
        return nop();
    endfunction

    task automatic model_step(input int i, input bit en_csr, input bit en_at);
        bit unk, amo;
        logic [16:0] w;
        if (reset || flush) begin
            m_word[i] = nop(); m_ov[i] = 0; m_inv[i] = 0;
            m_amo_pending[i] = 0; m_window[i] = WINDOW;
            return;
        end
        if (!stall) begin
            if (m_amo_pending[i]) begin
                m_word[i] = pack(0,1,0,0,0,0,0,0,0,1,0,1, 2'd0, 2'd3, 1);
                m_ov[i] = 1; m_inv[i] = 0; m_amo_pending[i] = 0;
            end else if (in_valid) begin
                w = ref_decode(opcode, funct5, en_csr, en_at, unk, amo);
                m_word[i] = w; m_ov[i] = 1;
                m_inv[i] = unk && (m_window[i] == 0);
                m_amo_pending[i] = amo;
            end else begin
                m_word[i] = nop(); m_ov[i] = 0; m_inv[i] = 0;
            end
        end
        if (m_window[i] > 0) m_window[i]--;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] dut_word(input int i);
        return {rw[i], mw[i], mr[i], br[i], as[i], jp[i], lu[i], au[i], jl[i],
                rt[i], ct[i], ia[i], m2r[i], aop[i], ph[i]};
    endfunction

    // One clock: advance the model on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step(0, 1, 1);
        model_step(1, 0, 0);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("word[%0d]", i), 32'(dut_word(i)), 32'(m_word[i]));
            check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_ov[i]));
            check($sformatf("invalid_inst[%0d]", i), 32'(inv[i]), 32'(m_inv[i]));
            check($sformatf("busy[%0d]", i), 32'(bz[i]), 32'(m_amo_pending[i]));
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] f5);
        in_valid = 1; opcode = op; funct5 = f5;
        tick();
    endtask

    logic [6:0] op_pool [14];
    logic [4:0] f5_pool [4];

    initial begin
        op_pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                    7'b0101111, 7'b0101111, 7'b0000000, 7'b1111111};
        f5_pool = '{5'b00000, 5'b00010, 5'b00011, 5'b00001};

        reset = 1; flush = 0; stall = 0; in_valid = 0; opcode = '0; funct5 = '0;
        @(negedge clk);
        tick(); tick();
        check("reset_alu_op", 32'(aop[0]), 32'd3);
        check("reset_out_valid", 32'(ov[0]), 32'd0);

        // Window: two unflagged unknowns, then the third one is flagged.
        #2 reset = 0;
        issue(7'b0000000, 5'd0);
        check("window_c1", 32'(inv[0]), 32'd0);
        issue(7'b0000000, 5'd0);
        check("window_c2", 32'(inv[0]), 32'd0);
        issue(7'b0000000, 5'd0);
        check("unknown_flag", 32'(inv[0]), 32'd1);
        check("unknown_rw", 32'(rw[0]), 32'd0);
        check("unknown_ov", 32'(ov[0]), 32'd1);
        issue(7'b1110011, 5'd0);
        check("csr_disabled_flag", 32'(inv[1]), 32'd1);
        check("csr_enabled_noflag", 32'(inv[0]), 32'd0);

        // Back-to-back legal classes.
        issue(7'b0000011, 5'd0);
        check("load_m2r", 32'(m2r[0]), 32'd1);
        check("load_alu_src", 32'(as[0]), 32'd1);
        check("load_alu_op", 32'(aop[0]), 32'd0);
        issue(7'b0100011, 5'd0);
        issue(7'b1100011, 5'd0);
        issue(7'b1101111, 5'd0);
        issue(7'b1110011, 5'd0);

        // AMOADD: read phase then write phase.
        issue(7'b0101111, 5'b00000);
        check("amo_rd_mem_read", 32'(mr[0]), 32'd1);
        check("amo_rd_busy", 32'(bz[0]), 32'd1);
        in_valid = 0;
        tick();
        check("amo_wr_mem_write", 32'(mw[0]), 32'd1);
        check("amo_wr_phase", 32'(ph[0]), 32'd1);
        check("amo_wr_busy", 32'(bz[0]), 32'd0);

        // AMO read, 3 stalled cycles, then one write phase only.
        issue(7'b0101111, 5'b00001);
        in_valid = 0; stall = 1;
        tick(); tick(); tick();
        check("stall_busy_held", 32'(bz[0]), 32'd1);
        stall = 0;
        tick();
        check("stall_release_wr", 32'(mw[0]), 32'd1);
        tick();
        check("single_wr", 32'(mw[0]), 32'd0);

        // Flush with stall while in the write phase.
        issue(7'b0101111, 5'b00000);
        in_valid = 0; stall = 1; flush = 1;
        tick();
        check("flush_busy", 32'(bz[0]), 32'd0);
        check("flush_no_wr", 32'(mw[0]), 32'd0);
        check("flush_ov", 32'(ov[0]), 32'd0);
        stall = 0; flush = 0;
        issue(7'b0000000, 5'd0);
        issue(7'b0000000, 5'd0);
        check("flush_window", 32'(inv[0]), 32'd0);
        issue(7'b0000000, 5'd0);
        check("flush_window_end", 32'(inv[0]), 32'd1);

        // Randomised traffic.
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(63) == 0);
            flush    = ($urandom_range(15) == 0);
            stall    = ($urandom_range(3) == 0);
            in_valid = ($urandom_range(3) != 0);
            opcode   = ($urandom_range(7) == 0) ? 7'($urandom) : op_pool[$urandom_range(13)];
            funct5   = ($urandom_range(3) == 0) ? 5'($urandom) : f5_pool[$urandom_range(3)];
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
